pulse_burst_controller: RTL
===========================

// Module: pulse_burst_controller
//
// PURPOSE
//   Sequences a programmable burst of single-cycle pulses: on a start request it latches a
//   period P and a pulse count C, then emits C pulses spaced P clocks apart.
//   It reports busy while running, and emits a one-cycle done strobe at normal completion.
//   Used wherever a fixed-rate tick stream must run for a bounded number of events
//   (sample triggers, LED blink sequences, stepper steps), with abort support.
//
// PARAMETERS
//   N  8  width of period input and internal tick counter
//   M  8  width of count input and pulses_left
//
// PORTS
//   clk          in   1  clock
//   rst          in   1  reset, synchronous, active-high
//   start        in   1  request a burst; sampled only while idle (busy=0)
//   period       in   N  pulse spacing P in clocks; sampled with accepted start
//   count        in   M  number of pulses C; sampled with accepted start
//   abort        in   1  terminate a running burst immediately
//   busy         out  1  burst in progress
//   pulse        out  1  one-cycle output pulse
//   done         out  1  one-cycle strobe: burst completed normally
//   pulses_left  out  M  pulses still to be issued in current burst
//
// BEHAVIOUR
//   - All outputs registered. Reset: state IDLE; busy=0, pulse=0, done=0, pulses_left=0.
//     Tick counter and latched P/C cleared. rst has priority over every other input.
//   - States: IDLE, RUN. done is a one-cycle flag raised on the RUN->IDLE edge; it is not a state.
//   - Acceptance: edge E0 where state=IDLE and start=1. Cycles are numbered 1,2,...
//     after E0.
//     - P!=0 and C!=0: latch P and C, pulses_left<=C, tick counter<=0, go RUN.
//       busy=1 from cycle 1.
//     - P==0 or C==0: stay IDLE, busy stays 0, no pulse, done=1 in cycle 1 only.
//   - RUN: tick counter increments each clock, 1..P.
//     - When the counter reaches P it reloads to 1 for the next period.
//     - pulse=1 in cycles k*P for k=1..C, else 0. P=1 gives C back-to-back pulse cycles.
//     - pulses_left decrements on the same edge that raises pulse. It reads C-k during
//       pulse cycle k and 0 in the last pulse cycle.
//     - After the last pulse cycle (C*P): IDLE, busy=0, done=1 in cycle C*P+1.
//     - busy=1 in cycles 1..C*P inclusive.
//   - start while busy=1: ignored, including in the last pulse cycle. Latched P/C are
//     unaffected by input changes during RUN.
//   - start in the done cycle: accepted normally, since the state is IDLE. Back-to-back
//     bursts are therefore possible with a one-cycle gap.
//   - abort=1 at any RUN edge:
//     - Next cycle: IDLE, busy=0, pulse=0, pulses_left=0, done=0 (no done strobe).
//     - abort beats a pulse due at that edge; the pulse is suppressed.
//     - A pulse already high in the current cycle is unaffected.
//   - abort in IDLE: no effect. abort and start together in IDLE: start accepted
//     (abort applies only in RUN).
//   - Arithmetic: counter and comparisons are unsigned, N bits; P=2^N-1 must work with
//     no wrap. C=2^M-1 must issue exactly 2^M-1 pulses.
//   - rst mid-burst: next cycle matches the reset state; no done, no further pulses.
//
// TESTING
//   1. P=3,C=2 at E0 -> pulse in cycles 3,6; busy cycles 1-6; done cycle 7 only;
//      pulses_left 2,2,1,1,1,0 over cycles 1-6.
//   2. P=1,C=4 -> pulse cycles 1-4 contiguous; done cycle 5; start in cycle 5 with P=2,C=1
//      -> pulse cycle 7, done cycle 8.
//   3. P=0,C=5 and separately P=4,C=0 -> done cycle 1 only; busy, pulse never high.
//   4. P=4,C=3: start with P=1,C=9 in cycle 2 -> ignored, pulses remain 4,8,12.
//      Abort sampled at edge ending cycle 7 -> cycle 8 pulse suppressed; busy=0 from cycle 8;
//      no done.
//   5. P=2,C=3, rst high for one edge ending cycle 3 -> from cycle 4 all outputs 0, no done;
//      new start then behaves as test 1.
//   6. P=255,C=2 (N=8) -> pulses cycles 255,510; done cycle 511; no early/wrapped pulse.

Source files
------------

// File: rtl/pulse_burst_controller.sv
// Programmable pulse-burst sequencer: emits C single-cycle pulses spaced P clocks apart
// after an accepted start, with abort support and a one-cycle done strobe.
module pulse_burst_controller #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] period,
    input  logic [M-1:0] count,
    input  logic         abort,
    output logic         busy,
    output logic         pulse,
    output logic         done,
    output logic [M-1:0] pulses_left
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] tick_q, tick_d;
    logic [N-1:0] period_q, period_d;
    logic [M-1:0] left_q, left_d;
    logic         busy_q, busy_d;
    logic         pulse_q, pulse_d;
    logic         done_q, done_d;
    logic         first_is_pulse;

    // tick holds (position within period - 1) for the current cycle, so it never exceeds P-1.
    assign first_is_pulse = (period == N'(1));

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        period_d = period_q;
        left_d   = left_q;
        busy_d   = 1'b0;
        pulse_d  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                left_d = '0;
                if (start) begin
                    if (period != '0 && count != '0) begin
                        state_d  = StRun;
                        period_d = period;
                        tick_d   = '0;
                        busy_d   = 1'b1;
                        pulse_d  = first_is_pulse;
                        left_d   = count - {{(M-1){1'b0}}, first_is_pulse};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    tick_d  = '0;
                    left_d  = '0;
                end else if (pulse_q && left_q == '0) begin
                    // Last pulse cycle just ended.
                    state_d = StIdle;
                    tick_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    tick_d  = (tick_q == period_q - N'(1)) ? '0 : tick_q + N'(1);
                    pulse_d = (tick_d == period_q - N'(1));
                    if (pulse_d) begin
                        left_d = left_q - M'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            period_q <= '0;
            left_q   <= '0;
            busy_q   <= 1'b0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            left_q   <= left_d;
            busy_q   <= busy_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign pulse       = pulse_q;
    assign done        = done_q;
    assign pulses_left = left_q;

endmodule
